// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped interval timer.
//
// Contents:
//   - Register byte offsets from the timer base address (TH, TL, TCON).
//   - TCON bit positions (EN, IE, ST).
//   - Reset value of the reload register.
//   - reg_sel_e: which timer register a bus address selects.
//   - timer_decode(): maps a word address onto reg_sel_e.
package timer_pkg;

  localparam logic [3:0] TH_OFS   = 4'h0;
  localparam logic [3:0] TL_OFS   = 4'h4;
  localparam logic [3:0] TCON_OFS = 4'h8;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  localparam logic [31:0] TH_RESET = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_TH,
    SEL_TL,
    SEL_TCON
  } reg_sel_e;

  // The CPU ignores byte lanes for these registers, so decode works on word
  // addresses only. The offset is taken relative to the base so the window
  // does not alias anywhere else in the address space.
  function automatic reg_sel_e timer_decode(input logic [29:0] word_addr,
                                            input logic [29:0] base_word);
    logic [29:0] ofs;
    reg_sel_e    sel;
    ofs = word_addr - base_word;
    sel = SEL_NONE;
    if (ofs == {28'd0, TH_OFS[3:2]})        sel = SEL_TH;
    else if (ofs == {28'd0, TL_OFS[3:2]})   sel = SEL_TL;
    else if (ofs == {28'd0, TCON_OFS[3:2]}) sel = SEL_TCON;
    return sel;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Count-rate divider for the interval timer.
//
// Only present when TIMER_PRESCALE_EN is defined; the default build ticks
// the timer on every enabled cycle and has no use for this module.
//
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   en     in  count enable (TCON.EN); low holds the divider at 0
//   tick   out high for one cycle each time the divider wraps
//
// Parameters:
//   PRESCALE  divide ratio, legal range 1..65535
`ifdef TIMER_PRESCALE_EN
module timer_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] count;

  // Divider counts 0..PRESCALE-1 while enabled. Dropping the enable restarts
  // the divide from zero so a re-enabled timer always waits a full period
  // before its first tick. With PRESCALE=1 the count sits at 0 and every
  // enabled cycle is a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!en || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

  // The wrap cycle itself is the tick.
  assign tick = en && (count == LAST);

endmodule
`endif

// File: rtl/timer_irq_unit.sv
// Memory-mapped interval timer and interrupt source.
//
// Sits on the data-memory bus beside data RAM and answers lw/sw accesses to
// three word registers:
//   BASE_ADDR+0  TH    reload value
//   BASE_ADDR+4  TL    counter
//   BASE_ADDR+8  TCON  {29'b0, ST, IE, EN}
// TL counts up on each tick; on a tick at all-ones it reloads from TH and, if
// IE is set, sets ST. IRQ = IE & ST, held until software clears either bit.
//
// Configuration macro: TIMER_PRESCALE_EN
//   defined   - ticks come from timer_prescaler every PRESCALE enabled cycles
//   undefined - every enabled cycle is a tick; no PRESCALE parameter
//
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous, active-high reset
//   MemRd      in  load strobe from the MEM stage
//   MemWr      in  store strobe from the MEM stage
//   Addr       in  byte address, bits [1:0] ignored
//   WriteData  in  store data
//   ReadData   out load data, 0 unless MemRd and Hit
//   Hit        out Addr falls on one of the three timer registers
//   IRQ        out registered level interrupt request
module timer_irq_unit
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
`ifdef TIMER_PRESCALE_EN
  ,
  parameter int unsigned PRESCALE = 4
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        IRQ
);

  reg_sel_e    sel;
  logic        wr_th;
  logic        wr_tl;
  logic        wr_tcon;
  logic        tick;
  logic        overflow;
  logic        unused_addr_bits;

  logic [31:0] th;
  logic [31:0] tl;
  logic        tcon_en;
  logic        tcon_ie;
  logic        tcon_st;
  logic        irq_q;

  logic [31:0] th_next;
  logic [31:0] tl_next;
  logic        en_next;
  logic        ie_next;
  logic        st_next;
  logic        irq_next;

  assign unused_addr_bits = ^Addr[1:0];

  assign sel     = timer_decode(Addr[31:2], BASE_ADDR[31:2]);
  assign Hit     = (sel != SEL_NONE);
  assign wr_th   = MemWr && (sel == SEL_TH);
  assign wr_tl   = MemWr && (sel == SEL_TL);
  assign wr_tcon = MemWr && (sel == SEL_TCON);

`ifdef TIMER_PRESCALE_EN
  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (tcon_en),
    .tick  (tick)
  );
`else
  assign tick = tcon_en;
`endif

  // A CPU store to TL replaces the count outright, so it also cancels any
  // overflow the tick in that cycle would have produced.
  assign overflow = tick && (tl == 32'hFFFF_FFFF) && !wr_tl;

  // Load path is purely combinational so the timer answers in the same
  // cycle as a RAM load. Because it reads the current registers, a combined
  // read+write shows the value from before the write.
  always_comb begin
    ReadData = '0;
    if (MemRd) begin
      case (sel)
        SEL_TH:   ReadData = th;
        SEL_TL:   ReadData = tl;
        SEL_TCON: ReadData = {29'd0, tcon_st, tcon_ie, tcon_en};
        default:  ReadData = '0;
      endcase
    end
  end

  // Next-state for all timer registers. Ordering encodes the collision
  // rules: a TL store beats the tick, the reload reads the old TH even when
  // TH is being stored, a TCON store with EN=0 does not cancel this cycle's
  // tick (tick depends on the current EN), and an overflow setting ST is
  // applied after a software clear so a simultaneous interrupt is not lost.
  // Software can only clear ST, never set it.
  always_comb begin
    th_next  = th;
    tl_next  = tl;
    en_next  = tcon_en;
    ie_next  = tcon_ie;
    st_next  = tcon_st;
    irq_next = 1'b0;

    if (wr_th) begin
      th_next = WriteData;
    end

    if (wr_tl) begin
      tl_next = WriteData;
    end else if (tick) begin
      tl_next = (tl == 32'hFFFF_FFFF) ? th : tl + 32'd1;
    end

    if (wr_tcon) begin
      en_next = WriteData[TCON_EN];
      ie_next = WriteData[TCON_IE];
      if (!WriteData[TCON_ST]) begin
        st_next = 1'b0;
      end
    end

    if (overflow && tcon_ie) begin
      st_next = 1'b1;
    end

    irq_next = ie_next && st_next;
  end

  // Register state. IRQ has its own flop fed from the next-state values so
  // it changes on the same edge as ST/IE yet never carries decode glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th      <= TH_RESET;
      tl      <= '0;
      tcon_en <= 1'b0;
      tcon_ie <= 1'b0;
      tcon_st <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      th      <= th_next;
      tl      <= tl_next;
      tcon_en <= en_next;
      tcon_ie <= ie_next;
      tcon_st <= st_next;
      irq_q   <= irq_next;
    end
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_irq_unit.sv
// Self-checking bench for timer_irq_unit.
//
// Register reads are scoreboarded: each test pushes the values it expects
// onto exp_q, then drains the queue by issuing loads and comparing. IRQ and
// Hit are compared inline. Cycle-exact counting tests assume the default
// build; with TIMER_PRESCALE_EN the prescaler test takes their place.
module tb_timer_irq_unit;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRd = 1'b0;
  logic        MemWr = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        Hit;
  logic        IRQ;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;

  timer_irq_unit dut (
    .clk       (clk),
    .reset     (reset),
    .MemRd     (MemRd),
    .MemWr     (MemWr),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .IRQ       (IRQ)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Runaway guard so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void push_exp(input string name, input logic [31:0] addr,
                                   input logic [31:0] data);
    exp_t e;
    e.name = name;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  // One store, committed at the next rising edge; returns 1 ns after it.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    Addr      = a;
    WriteData = d;
    MemWr     = 1'b1;
    @(posedge clk);
    #1;
    MemWr = 1'b0;
  endtask

  // One load; combinational, so no clock edge is consumed.
  task automatic sample_bus(input logic [31:0] a, output logic [31:0] d, output logic h);
    Addr  = a;
    MemRd = 1'b1;
    #1;
    d     = ReadData;
    h     = Hit;
    MemRd = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    logic [31:0] rd;
    logic hit;
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset_th", A_TH, 32'h0);
    push_exp("reset_tl", A_TL, 32'h0);
    push_exp("reset_tcon", A_TCON, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    n_vec++;
    if (IRQ !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL reset_irq: IRQ=%b, expected 0", IRQ);
    end
    Addr  = A_TL;
    MemRd = 1'b0;
    #1;
    n_vec++;
    if (ReadData !== 32'h0) begin
      n_miss++;
      $display("[TB] FAIL reset_rdata_idle: ReadData=%h, expected 0", ReadData);
    end
    reset = 1'b0;

    applyStimulus(A_TH, 32'h0000_00AB);
    applyStimulus(A_TL, 32'h0000_0010);
    applyStimulus(A_TCON, 32'h0000_0003);
    push_exp("pre_reset_tl", A_TL, 32'h0000_0010);
    push_exp("pre_reset_tcon", A_TCON, 32'h0000_0003);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end

    reset = 1'b1;
    #1;
    push_exp("midcount_th", A_TH, 32'h0);
    push_exp("midcount_tl", A_TL, 32'h0);
    push_exp("midcount_tcon", A_TCON, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    n_vec++;
    if (IRQ !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL midcount_irq: IRQ=%b, expected 0", IRQ);
    end
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(2);
    push_exp("post_reset_tl_idle", A_TL, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
  endtask

  task automatic test_reload_irq;
    exp_t e;
    logic [31:0] rd;
    logic hit;
    applyStimulus(A_TH, 32'hFFFF_FFFC);
    applyStimulus(A_TL, 32'hFFFF_FFFC);
    applyStimulus(A_TCON, 32'h0000_0003);
    for (int i = 1; i <= 4; i++) begin
      wait_cycles(1);
      n_vec++;
      if (IRQ !== (i == 4)) begin
        n_miss++;
        $display("[TB] FAIL reload_irq_cycle%0d: IRQ=%b, expected %b", i, IRQ, (i == 4));
      end
    end
    push_exp("reload_tl", A_TL, 32'hFFFF_FFFC);
    push_exp("reload_tcon", A_TCON, 32'h0000_0007);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    wait_cycles(3);
    n_vec++;
    if (IRQ !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL irq_held: IRQ=%b, expected 1", IRQ);
    end
    push_exp("reload_tl_recount", A_TL, 32'hFFFF_FFFF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
  endtask

  task automatic test_clear;
    exp_t e;
    logic [31:0] rd;
    logic hit;
    applyStimulus(A_TL, 32'h0000_0100);
    applyStimulus(A_TCON, 32'h0000_0003);
    n_vec++;
    if (IRQ !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL clear_irq: IRQ=%b, expected 0", IRQ);
    end
    push_exp("clear_tcon", A_TCON, 32'h0000_0003);
    push_exp("clear_tl", A_TL, 32'h0000_0101);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    wait_cycles(1);
    push_exp("clear_tl_counting", A_TL, 32'h0000_0102);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end

    applyStimulus(A_TL, 32'hFFFF_FFFF);
    applyStimulus(A_TCON, 32'h0000_0003);
    n_vec++;
    if (IRQ !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL clear_vs_overflow_irq: IRQ=%b, expected 1", IRQ);
    end
    push_exp("clear_vs_overflow_tcon", A_TCON, 32'h0000_0007);
    push_exp("clear_vs_overflow_tl", A_TL, 32'hFFFF_FFFC);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
  endtask

  task automatic test_tcon_write;
    exp_t e;
    logic [31:0] rd;
    logic hit;
    applyStimulus(A_TCON, 32'hFFFF_FFFF);
    push_exp("tcon_all_ones_st_set", A_TCON, 32'h0000_0007);
    push_exp("tcon_all_ones_tl", A_TL, 32'hFFFF_FFFD);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    applyStimulus(A_TCON, 32'h0000_0000);
    n_vec++;
    if (IRQ !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL tcon_stop_irq: IRQ=%b, expected 0", IRQ);
    end
    wait_cycles(2);
    push_exp("stop_edge_tick_applied", A_TL, 32'hFFFF_FFFE);
    push_exp("stop_tcon", A_TCON, 32'h0000_0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    applyStimulus(A_TCON, 32'hFFFF_FFFF);
    push_exp("tcon_all_ones_st_clear", A_TCON, 32'h0000_0003);
    push_exp("enable_edge_no_tick", A_TL, 32'hFFFF_FFFE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    applyStimulus(A_TCON, 32'h0000_0000);
  endtask

  task automatic test_collisions;
    exp_t e;
    logic [31:0] rd;
    logic hit;
    applyStimulus(A_TCON, 32'h0000_0001);
    applyStimulus(A_TH, 32'h0000_0055);
    n_vec++;
    if (IRQ !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL th_collision_irq: IRQ=%b, expected 0", IRQ);
    end
    push_exp("reload_uses_old_th", A_TL, 32'hFFFF_FFFC);
    push_exp("th_written", A_TH, 32'h0000_0055);
    push_exp("ie_off_no_st", A_TCON, 32'h0000_0001);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    applyStimulus(A_TL, 32'h0000_1000);
    push_exp("tl_write_beats_tick", A_TL, 32'h0000_1000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    applyStimulus(A_TCON, 32'h0000_0000);
  endtask

  task automatic test_ie_off;
    exp_t e;
    logic [31:0] rd;
    logic hit;
    applyStimulus(A_TH, 32'hFFFF_FFFC);
    applyStimulus(A_TL, 32'hFFFF_FFFC);
    applyStimulus(A_TCON, 32'h0000_0001);
    for (int i = 1; i <= 6; i++) begin
      wait_cycles(1);
      n_vec++;
      if (IRQ !== 1'b0) begin
        n_miss++;
        $display("[TB] FAIL ie_off_irq_cycle%0d: IRQ=%b, expected 0", i, IRQ);
      end
      if (i == 4) begin
        push_exp("ie_off_reload_tl", A_TL, 32'hFFFF_FFFC);
        push_exp("ie_off_tcon", A_TCON, 32'h0000_0001);
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          sample_bus(e.addr, rd, hit);
          n_vec++;
          if (rd !== e.data) begin
            n_miss++;
            $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
          end
        end
      end
    end
    applyStimulus(A_TCON, 32'h0000_0000);
  endtask

  task automatic test_bus_decode;
    exp_t e;
    logic [31:0] rd;
    logic hit;
    applyStimulus(A_TCON, 32'h0000_0000);
    applyStimulus(A_TH, 32'hFFFF_FFFC);
    applyStimulus(A_TL, 32'h1234_5678);

    sample_bus(32'h4000_000C, rd, hit);
    n_vec++;
    if (hit !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL decode_past_window_hit: Hit=%b, expected 0", hit);
    end
    n_vec++;
    if (rd !== 32'h0) begin
      n_miss++;
      $display("[TB] FAIL decode_past_window_rdata: read %h, expected 00000000", rd);
    end
    sample_bus(32'h3FFF_FFFC, rd, hit);
    n_vec++;
    if (hit !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL decode_below_window_hit: Hit=%b, expected 0", hit);
    end
    sample_bus(32'h4000_0006, rd, hit);
    n_vec++;
    if (hit !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL decode_low_bits_hit: Hit=%b, expected 1", hit);
    end
    push_exp("decode_low_bits_tl", 32'h4000_0006, 32'h1234_5678);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    Addr  = A_TH;
    MemRd = 1'b0;
    #1;
    n_vec++;
    if (Hit !== 1'b1 || ReadData !== 32'h0) begin
      n_miss++;
      $display("[TB] FAIL no_strobe_read: Hit=%b ReadData=%h, expected Hit=1 ReadData=00000000", Hit, ReadData);
    end

    applyStimulus(32'h4000_000C, 32'hDEAD_BEEF);
    applyStimulus(32'h0000_0004, 32'h0BAD_0BAD);
    push_exp("stray_write_th", A_TH, 32'hFFFF_FFFC);
    push_exp("stray_write_tl", A_TL, 32'h1234_5678);
    push_exp("stray_write_tcon", A_TCON, 32'h0000_0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end

    Addr      = A_TH;
    WriteData = 32'h0000_CAFE;
    MemWr     = 1'b1;
    MemRd     = 1'b1;
    #1;
    n_vec++;
    if (ReadData !== 32'hFFFF_FFFC) begin
      n_miss++;
      $display("[TB] FAIL rdwr_pre_write: read %h, expected fffffffc", ReadData);
    end
    @(posedge clk);
    #1;
    MemWr = 1'b0;
    MemRd = 1'b0;
    applyStimulus(32'h4000_0007, 32'h0000_0BAD);
    push_exp("byte_offset_store_tl", A_TL, 32'h0000_0BAD);
    push_exp("rdwr_committed_th", A_TH, 32'h0000_CAFE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
  endtask

  task automatic test_prescale;
    exp_t e;
    logic [31:0] rd;
    logic hit;
    applyStimulus(A_TL, 32'h0000_0000);
    applyStimulus(A_TCON, 32'h0000_0001);
`ifdef TIMER_PRESCALE_EN
    wait_cycles(3);
    push_exp("prescale_3_cycles", A_TL, 32'h0000_0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    wait_cycles(1);
    push_exp("prescale_4_cycles", A_TL, 32'h0000_0001);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    wait_cycles(8);
    push_exp("prescale_12_cycles", A_TL, 32'h0000_0003);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    wait_cycles(2);
    applyStimulus(A_TCON, 32'h0000_0000);
    applyStimulus(A_TCON, 32'h0000_0001);
    wait_cycles(3);
    push_exp("prescale_restart_3", A_TL, 32'h0000_0003);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    wait_cycles(1);
    push_exp("prescale_restart_4", A_TL, 32'h0000_0004);
`else
    wait_cycles(4);
    push_exp("noprescale_4_cycles", A_TL, 32'h0000_0004);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    wait_cycles(8);
    push_exp("noprescale_12_cycles", A_TL, 32'h0000_000C);
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample_bus(e.addr, rd, hit);
      n_vec++;
      if (rd !== e.data) begin
        n_miss++;
        $display("[TB] FAIL %s: read %h, expected %h", e.name, rd, e.data);
      end
    end
    applyStimulus(A_TCON, 32'h0000_0000);
  endtask

  initial begin
    $display("[TB] timer_irq_unit bench starting");
    test_reset();
`ifndef TIMER_PRESCALE_EN
    test_reload_irq();
    test_clear();
    test_tcon_write();
    test_collisions();
    test_ie_off();
`endif
    test_bus_decode();
    test_prescale();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
